matrix_calc_core: RTL and testbench
===================================

Name: matrix_calc_core

Overview:
- Matrix arithmetic engine between the main FSM controller and the shared single-port matrix storage.
- When the controller raises a start request, the core reads operands through the storage mux and computes element by element.
- It writes each result word back to storage at the controller-supplied result base, then signals done.
- Supported operations: transpose, addition, scalar multiply and matrix multiply on signed 32-bit elements, row-major layout.

Parameters:
- DW, 32, element data width (two's complement).
- AW, 8, storage address width.
- DIMW, 3, dimension field width (legal dims 1..5).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_start_calc  in  1  level request; controller holds high until o_calc_done
- i_op_code  in  3  000 transpose, 001 add, 010 scalar mul, 011 mat mul; others illegal
- i_op1_addr  in  AW  operand 1 base address
- i_op1_m, i_op1_n  in  DIMW  operand 1 rows/cols
- i_op2_addr  in  AW  operand 2 base (add/matmul only)
- i_op2_m, i_op2_n  in  DIMW  operand 2 rows/cols
- i_scalar  in  DW  scalar for op 010
- i_res_addr  in  AW  result base address
- i_storage_rdata  in  DW  storage read data, valid 1 cycle after address
- o_calc_req_addr  out  AW  read address
- o_calc_we  out  1  write strobe
- o_calc_waddr  out  AW  write address
- o_calc_wdata  out  DW  write data
- o_res_m, o_res_n  out  DIMW  result dimensions, valid from done onward
- o_calc_err  out  1  dimension/opcode error, valid with done
- o_calc_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators 0.
- Parent mux: address = o_calc_we ? o_calc_waddr : o_calc_req_addr. The core never reads and writes in the same cycle.
- Element address = base + row*cols + col, modulo 2^AW (wrap silently).
- States: IDLE, CHECK, RD1, CAP1, RD2, CAP2, ACC, WR, DONE, HOLD.
- IDLE -> CHECK on rising edge of i_start_calc. All i_* operands are latched at this transition and are ignored afterwards.
- CHECK validates the request:
  - add: m1==m2 and n1==n2.
  - matmul: n1==m2.
  - All ops: dims nonzero.
  - Opcode must be 000..011.
  - On failure go to DONE with o_calc_err=1; no writes occur.
- Result dims:
  - transpose: n1 x m1.
  - add and scalar: m1 x n1.
  - matmul: m1 x n2.
- Loop over result element (i,j) in row-major order:
  - transpose: read op1[j][i].
  - add: read op1[i][j], then op2[i][j]; sum.
  - scalar: read op1[i][j]; multiply by scalar.
  - matmul: acc=0; for k=0..n1-1 read op1[i][k], op2[k][j]; acc += product.
- Each read: RDx drives the address for one cycle; CAPx captures i_storage_rdata the next cycle.
- WR: o_calc_we=1 for exactly one cycle, with o_calc_waddr = i_res_addr + i*res_n + j and o_calc_wdata = result. In every other cycle o_calc_we=0.
- Arithmetic is DW-bit signed. Products and sums are truncated to DW bits, with no saturation.
- DONE: o_calc_done=1 for one cycle, then HOLD.
- HOLD returns to IDLE when i_start_calc is low, so a held start never retriggers.
- i_start_calc dropping mid-operation aborts: return to IDLE next cycle, no done pulse. Writes already issued remain.
- Asynchronous reset mid-operation forces IDLE immediately.
- o_res_m/o_res_n/o_calc_err hold until the next start.

Test Plan:
- Add: A=[4 5 6;7 8 9] at 0, op2=A at 0, res at 20.
  - Expect mem[20..25] = 8,10,12,14,16,18.
  - Expect 6 write strobes and done with err=0.
- Matmul: B=[4 2;5 1] at 12 as both operands, res at 26.
  - Expect mem[26..29] = 26,10,25,11 and res dims 2x2.
- Transpose: A at 0, res at 40.
  - Expect 40..45 = 4,7,5,8,6,9 and res dims 3x2.
- Scalar: B at 12, i_scalar=3, res at 50.
  - Expect 12,6,15,3.
  - With i_scalar=-1, expect -4,-2,-5,-1.
- Errors: add of 2x3 with 2x2, matmul of 2x3 with 2x3, and op 111.
  - Each gives a done pulse with err=1 and zero write strobes.
- Handshake:
  - Hold start high 100 cycles after done: exactly one done pulse.
  - Deassert start mid-matmul: no done, core IDLE.
  - Base 254 addresses wrap to 0.

Source files
------------

// File: rtl/matrix_calc_core.sv
// Matrix arithmetic engine: transpose, add, scalar and matrix multiply
// over a shared single-port storage, one element read per two cycles.
module matrix_calc_core #(
    parameter int DW   = 32,
    parameter int AW   = 8,
    parameter int DIMW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start_calc,
    input  logic [2:0]      i_op_code,
    input  logic [AW-1:0]   i_op1_addr,
    input  logic [DIMW-1:0] i_op1_m,
    input  logic [DIMW-1:0] i_op1_n,
    input  logic [AW-1:0]   i_op2_addr,
    input  logic [DIMW-1:0] i_op2_m,
    input  logic [DIMW-1:0] i_op2_n,
    input  logic [DW-1:0]   i_scalar,
    input  logic [AW-1:0]   i_res_addr,
    input  logic [DW-1:0]   i_storage_rdata,
    output logic [AW-1:0]   o_calc_req_addr,
    output logic            o_calc_we,
    output logic [AW-1:0]   o_calc_waddr,
    output logic [DW-1:0]   o_calc_wdata,
    output logic [DIMW-1:0] o_res_m,
    output logic [DIMW-1:0] o_res_n,
    output logic            o_calc_err,
    output logic            o_calc_done
);

    localparam logic [2:0] OP_TR  = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SC  = 3'd2;
    localparam logic [2:0] OP_MM  = 3'd3;
    localparam logic [DIMW-1:0] ONE = DIMW'(1);

    typedef enum logic [3:0] {
        IDLE, CHECK, RD1, CAP1, RD2, CAP2, ACC, WR, DONE, HOLD
    } state_t;

    state_t state, state_nx;

    logic                   start_q;
    logic [2:0]             op;
    logic [AW-1:0]          a1, a2, ra;
    logic [DIMW-1:0]        m1, n1, m2, n2;
    logic [DIMW-1:0]        i, j, k;
    logic signed [DW-1:0]   scal, opa, opb, acc;
    logic [DIMW-1:0]        res_m, res_n;
    logic                   err;

    logic                   ok;
    logic                   rise;
    logic                   busy;
    logic                   last_k;
    logic                   last_el;
    logic [DIMW-1:0]        rm_c, rn_c;
    logic [AW-1:0]          addr1, addr2, waddr;

    // base + row*cols + col, wrapping modulo 2^AW
    function automatic logic [AW-1:0] elem(
        input logic [AW-1:0]   b,
        input logic [DIMW-1:0] r,
        input logic [DIMW-1:0] c,
        input logic [DIMW-1:0] cols
    );
        logic [AW-1:0] rr, cc, nn;
        rr = AW'(r);
        cc = AW'(c);
        nn = AW'(cols);
        return b + rr * nn + cc;
    endfunction

    always_comb begin
        ok = !op[2] && (m1 != '0) && (n1 != '0);
        if (op == OP_ADD) ok = ok && (m1 == m2) && (n1 == n2);
        if (op == OP_MM)  ok = ok && (n1 == m2) && (n2 != '0);
        rm_c = m1;
        rn_c = n1;
        if (op == OP_TR) begin
            rm_c = n1;
            rn_c = m1;
        end
        if (op == OP_MM) rn_c = n2;
    end

    assign rise    = i_start_calc && !start_q;
    assign busy    = (state != IDLE) && (state != DONE) && (state != HOLD);
    assign last_k  = (k == n1 - ONE);
    assign last_el = (i == res_m - ONE) && (j == res_n - ONE);

    always_comb begin
        addr1 = elem(a1, i, (op == OP_MM) ? k : j, n1);
        if (op == OP_TR) addr1 = elem(a1, j, i, n1);
        addr2 = elem(a2, (op == OP_MM) ? k : i, j, n2);
        waddr = elem(ra, i, j, res_n);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (rise) state_nx = CHECK;
            CHECK: state_nx = ok ? RD1 : DONE;
            RD1:   state_nx = CAP1;
            CAP1:  state_nx = (op == OP_ADD || op == OP_MM) ? RD2 : ACC;
            RD2:   state_nx = CAP2;
            CAP2:  state_nx = ACC;
            ACC:   state_nx = (op == OP_MM && !last_k) ? RD1 : WR;
            WR:    state_nx = last_el ? DONE : RD1;
            DONE:  state_nx = HOLD;
            HOLD:  if (!i_start_calc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // a dropped request abandons the operation
        if (busy && !i_start_calc) state_nx = IDLE;
    end

    always_comb begin
        o_calc_req_addr = '0;
        if (state == RD1) o_calc_req_addr = addr1;
        if (state == RD2) o_calc_req_addr = addr2;
        o_calc_we    = (state == WR);
        o_calc_waddr = (state == WR) ? waddr : '0;
        o_calc_wdata = (state == WR) ? acc : '0;
        o_calc_done  = (state == DONE);
        o_res_m      = res_m;
        o_res_n      = res_n;
        o_calc_err   = err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
            op      <= '0;
            a1      <= '0;
            a2      <= '0;
            ra      <= '0;
            m1      <= '0;
            n1      <= '0;
            m2      <= '0;
            n2      <= '0;
            scal    <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
            res_m   <= '0;
            res_n   <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= i_start_calc;
            unique case (state)
                IDLE: if (rise) begin
                    op    <= i_op_code;
                    a1    <= i_op1_addr;
                    a2    <= i_op2_addr;
                    ra    <= i_res_addr;
                    m1    <= i_op1_m;
                    n1    <= i_op1_n;
                    m2    <= i_op2_m;
                    n2    <= i_op2_n;
                    scal  <= i_scalar;
                    err   <= 1'b0;
                    res_m <= '0;
                    res_n <= '0;
                end
                CHECK: begin
                    err   <= !ok;
                    res_m <= ok ? rm_c : '0;
                    res_n <= ok ? rn_c : '0;
                    i     <= '0;
                    j     <= '0;
                    k     <= '0;
                    acc   <= '0;
                end
                CAP1: opa <= i_storage_rdata;
                CAP2: opb <= i_storage_rdata;
                ACC: begin
                    unique case (1'b1)
                        op == OP_TR:  acc <= opa;
                        op == OP_ADD: acc <= opa + opb;
                        op == OP_SC:  acc <= opa * scal;
                        default:      acc <= acc + opa * opb;
                    endcase
                    if (op == OP_MM && !last_k) k <= k + ONE;
                end
                WR: begin
                    k   <= '0;
                    acc <= '0;
                    if (j == res_n - ONE) begin
                        j <= '0;
                        i <= i + ONE;
                    end else begin
                        j <= j + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_calc_core.sv
// Scoreboard bench for matrix_calc_core: directed plan cases plus
// randomized operations checked against an array-level reference model.
module tb_matrix_calc_core;

    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int DIMW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      op_code = '0;
    logic [AW-1:0]   op1_addr = '0, op2_addr = '0, res_addr = '0;
    logic [DIMW-1:0] op1_m = '0, op1_n = '0, op2_m = '0, op2_n = '0;
    logic [DW-1:0]   scalar = '0;
    logic [DW-1:0]   rdata = '0;
    logic [AW-1:0]   req_addr, waddr;
    logic            we, err, done;
    logic [DW-1:0]   wdata;
    logic [DIMW-1:0] res_m, res_n;

    always #5 clk = ~clk;

    matrix_calc_core #(.DW(DW), .AW(AW), .DIMW(DIMW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start_calc    (start),
        .i_op_code       (op_code),
        .i_op1_addr      (op1_addr),
        .i_op1_m         (op1_m),
        .i_op1_n         (op1_n),
        .i_op2_addr      (op2_addr),
        .i_op2_m         (op2_m),
        .i_op2_n         (op2_n),
        .i_scalar        (scalar),
        .i_res_addr      (res_addr),
        .i_storage_rdata (rdata),
        .o_calc_req_addr (req_addr),
        .o_calc_we       (we),
        .o_calc_waddr    (waddr),
        .o_calc_wdata    (wdata),
        .o_res_m         (res_m),
        .o_res_n         (res_n),
        .o_calc_err      (err),
        .o_calc_done     (done)
    );

    logic [DW-1:0] mem [256];
    logic          pl_en = 1'b0;
    logic [7:0]    pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    int            img [256];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (we) mem[waddr] <= wdata;
        rdata <= mem[we ? waddr : req_addr];
    end

    typedef struct { int a; logic [31:0] d; } wr_t;
    typedef struct { bit e; int m; int n; } dn_t;
    wr_t wq[$];
    dn_t dq[$];
    wr_t wexp;
    dn_t dexp;

    int total = 0, bad = 0, done_cnt = 0, wr_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && we) begin
            wr_cnt++;
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL write_extra got addr=%0d data=%0d required no write",
                         waddr, $signed(wdata));
            end else begin
                wexp = wq.pop_front();
                if (int'(waddr) != wexp.a || wdata !== wexp.d) begin
                    bad++;
                    $display("FAIL write got addr=%0d data=%0d required addr=%0d data=%0d",
                             waddr, $signed(wdata), wexp.a, $signed(wexp.d));
                end
            end
        end
        if (rst_n && done) begin
            done_cnt++;
            total++;
            if (dq.size() == 0) begin
                bad++;
                $display("FAIL done_extra got done=1 required no done");
            end else begin
                dexp = dq.pop_front();
                if (err !== dexp.e || wq.size() != 0 ||
                    (!dexp.e && (int'(res_m) != dexp.m || int'(res_n) != dexp.n))) begin
                    bad++;
                    $display("FAIL done got err=%0d dims=%0dx%0d pend=%0d required err=%0d dims=%0dx%0d pend=0",
                             err, res_m, res_n, wq.size(), dexp.e, dexp.m, dexp.n);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic poke(input int a, input int d);
        pl_en   = 1'b1;
        pl_addr = 8'(a);
        pl_data = 32'(d);
        img[a & 255] = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    function automatic int ea(input int b, input int r, input int c, input int cols);
        return (b + r * cols + c) & 255;
    endfunction

    task automatic model(input int op, input int a1, input int m1, input int n1,
                         input int a2, input int m2, input int n2,
                         input int s, input int ra);
        bit ok;
        int rm, rn, v;
        wr_t res[$];
        ok = op < 4 && m1 > 0 && n1 > 0;
        if (op == 1) ok = ok && m1 == m2 && n1 == n2;
        if (op == 3) ok = ok && n1 == m2 && n2 > 0;
        rm = (op == 0) ? n1 : m1;
        rn = (op == 0) ? m1 : (op == 3) ? n2 : n1;
        dq.push_back('{!ok, rm, rn});
        if (!ok) return;
        for (int r = 0; r < rm; r++) begin
            for (int c = 0; c < rn; c++) begin
                case (op)
                    0: v = img[ea(a1, c, r, n1)];
                    1: v = img[ea(a1, r, c, n1)] + img[ea(a2, r, c, n2)];
                    2: v = img[ea(a1, r, c, n1)] * s;
                    default: begin
                        v = 0;
                        for (int q = 0; q < n1; q++)
                            v += img[ea(a1, r, q, n1)] * img[ea(a2, q, c, n2)];
                    end
                endcase
                res.push_back('{ea(ra, r, c, rn), 32'(v)});
            end
        end
        foreach (res[x]) begin
            wq.push_back(res[x]);
            img[res[x].a] = int'(res[x].d);
        end
    endtask

    task automatic drive(input int op, input int a1, input int m1, input int n1,
                         input int a2, input int m2, input int n2,
                         input int s, input int ra);
        op_code  = 3'(op);
        op1_addr = 8'(a1);
        op1_m    = 3'(m1);
        op1_n    = 3'(n1);
        op2_addr = 8'(a2);
        op2_m    = 3'(m2);
        op2_n    = 3'(n2);
        scalar   = 32'(s);
        res_addr = 8'(ra);
    endtask

    task automatic run(input int op, input int a1, input int m1, input int n1,
                       input int a2, input int m2, input int n2,
                       input int s, input int ra, input int hold);
        int d0, w0;
        drive(op, a1, m1, n1, a2, m2, n2, s, ra);
        model(op, a1, m1, n1, a2, m2, n2, s, ra);
        d0 = done_cnt;
        w0 = wr_cnt;
        start = 1'b1;
        for (int t = 0; t < 3000 && done_cnt == d0; t++) @(posedge clk);
        #1;
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL timeout got no done required done op=%0d", op);
            wq.delete();
            dq.delete();
        end
        // other stimulus changes mid-op must be ignored once latched
        drive(7, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (hold) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (op == 7 || op == 4) check("err_writes", wr_cnt - w0, 0);
    endtask

    int op, m1, n1, m2, n2, w0, d0;

    initial begin
        #1;
        check("rst_addr", int'(req_addr), 0);
        check("rst_we", int'(we), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_dims", int'(res_m) + int'(res_n), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        poke(0, 4); poke(1, 5); poke(2, 6); poke(3, 7); poke(4, 8); poke(5, 9);
        poke(12, 4); poke(13, 2); poke(14, 5); poke(15, 1);
        poke(254, 10); poke(255, -3);

        run(1, 0, 2, 3, 0, 2, 3, 0, 20, 2);
        run(3, 12, 2, 2, 12, 2, 2, 0, 26, 2);
        run(0, 0, 2, 3, 0, 0, 0, 0, 40, 2);
        run(2, 12, 2, 2, 0, 0, 0, 3, 50, 2);
        run(2, 12, 2, 2, 0, 0, 0, -1, 50, 2);
        run(1, 0, 2, 3, 0, 2, 2, 0, 60, 2);
        run(3, 0, 2, 3, 0, 2, 3, 0, 60, 2);
        run(7, 0, 2, 3, 0, 2, 3, 0, 60, 2);
        run(1, 0, 2, 3, 0, 2, 3, 0, 20, 100);

        // abort in the middle of a 5x5 matmul, before any write
        drive(3, 64, 5, 5, 96, 5, 5, 0, 160);
        d0 = done_cnt;
        w0 = wr_cnt;
        start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_done", done_cnt - d0, 0);
        check("abort_writes", wr_cnt - w0, 0);
        check("abort_addr", int'(req_addr), 0);

        run(2, 254, 2, 2, 0, 0, 0, 5, 60, 2);
        run(2, 12, 2, 2, 0, 0, 0, 7, 254, 2);

        // asynchronous reset while busy
        drive(3, 64, 5, 5, 96, 5, 5, 0, 160);
        start = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_addr", int'(req_addr), 0);
        check("arst_dims", int'(res_m) + int'(res_n) + int'(err), 0);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int it = 0; it < 40; it++) begin
            op = ($urandom_range(0, 9) == 0) ? 4 + $urandom_range(0, 3)
                                              : $urandom_range(0, 3);
            m1 = $urandom_range(1, 5);
            n1 = $urandom_range(1, 5);
            m2 = $urandom_range(1, 5);
            n2 = $urandom_range(1, 5);
            if ($urandom_range(0, 3) != 0) begin
                if (op == 1) begin
                    m2 = m1;
                    n2 = n1;
                end
                if (op == 3) m2 = n1;
            end
            for (int x = 0; x < m1 * n1; x++) poke(64 + x, int'($urandom));
            for (int x = 0; x < m2 * n2; x++) poke(96 + x, int'($urandom));
            run(op, 64, m1, n1, 96, m2, n2, int'($urandom), 160, 1);
        end

        check("queues_empty", wq.size() + dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
